multicycle_main_control: RTL and testbench
==========================================

Name: multicycle_main_control

Overview:
Main control FSM for the multi-cycle MIPS datapath. It sits directly upstream of the ALU control decoder and drives its 2-bit alu_op, so that decoder sees 00 = add, 01 = subtract, 10 = decode funct. It sequences fetch, decode, execute, memory and writeback per opcode, stalls on memory wait states, traps on illegal opcodes and counts retired instructions.

Parameters:
RETIRE_W, 32, width of retired-instruction counter (wraps modulo 2^RETIRE_W)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  instruction[31:26] from IR, sampled in DECODE
mem_ready  in  1  memory handshake; access completes in cycle where mem_ready=1
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
iord  out  1  0 = PC addresses memory, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_to_reg  out  1  1 = MDR to register file, 0 = ALUOut
reg_dst  out  1  1 = rd, 0 = rt
reg_write  out  1  register file write
alu_src_a  out  1  0 = PC, 1 = A
alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
alu_op  out  2  to ALU control decoder
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  out  1  one-cycle pulse in final state of each instruction
illegal_op  out  1  high while in TRAP
retired  out  RETIRE_W  count of completed instructions
state  out  4  current state encoding (debug)

Behaviour:
- Reset: state = FETCH (0), retired = 0. Asynchronous on rst_n low; a mid-instruction reset abandons the instruction with no write strobe.
- Outputs are Moore-decoded from the state register, except that fetch strobes are gated by mem_ready. Unlisted outputs are 0.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, ALU_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, TRAP 12. Codes 13-15 go to FETCH on the next clock.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00. ir_write = pc_write = mem_ready. Go to DECODE when mem_ready, else hold. PC increments exactly once per fetch regardless of wait states.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00. Next state by opcode:
  - 100011 (lw) or 101011 (sw) -> MEM_ADDR
  - 000000 -> EXECUTE
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - 001000 -> ADDI_EXEC (only with feature; see below)
  - otherwise -> TRAP
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Go to MEM_READ for lw, MEM_WRITE for sw. Use the opcode latched in DECODE; the IR is stable after FETCH.
- MEM_READ: mem_read=1, iord=1. Hold until mem_ready, then go to MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1. Go to FETCH.
- MEM_WRITE: mem_write=1, iord=1. Hold until mem_ready. instr_done=mem_ready, then go to FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=10. Go to ALU_WB.
- ALU_WB: reg_dst=1, reg_write=1, instr_done=1. Go to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01, instr_done=1. Go to FETCH.
- JUMP: pc_write=1, pc_source=10, instr_done=1. Go to FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00. Go to ADDI_WB.
- ADDI_WB: reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1. Go to FETCH.
- TRAP: illegal_op=1 and all strobes 0. Sticky until reset. mem_ready is ignored.
- retired increments by 1 on each clock edge where instr_done=1. It wraps from all-ones to 0.
- Latency without wait states (cycles): R-type 4, lw 5, sw 4, beq 3, j 3, addi 4. Each cycle mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle.

Optional Feature:
MC_ADDI_EN. Defined: opcode 001000 decodes to ADDI_EXEC/ADDI_WB as above. Undefined: states 10/11 are not generated, and 001000 in DECODE goes to TRAP like any illegal opcode.

Test Plan:
- rst_n low then high, mem_ready=1, opcode=000000 -> states 0,1,6,7,0. alu_op=10 in state 6. reg_write=reg_dst=1 in state 7. retired=1 after 4 clocks.
- lw (100011) with mem_ready low for 2 cycles in FETCH and 3 cycles in MEM_READ -> pc_write pulses exactly once. MEM_WB asserts mem_to_reg=1, reg_write=1, reg_dst=0. Total 10 cycles.
- beq (000100) -> BRANCH asserts alu_op=01, pc_write_cond=1, pc_source=01. pc_write=0. instr_done pulses once.
- sw (101011) followed by j (000010) -> mem_write=1 with iord=1 only in state 5. JUMP asserts pc_write=1, pc_source=10. retired=2.
- opcode 111111 -> TRAP entered after DECODE, illegal_op=1 and no strobes for 20 cycles. Async rst_n pulse mid-cycle -> state=0, retired=0.
- opcode 001000 -> with MC_ADDI_EN: states 0,1,10,11,0, reg_write=1 with reg_dst=0 in state 11. Without it: TRAP.

Source files
------------

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: main control FSM for the multi-cycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback per opcode, stalls on memory
// wait states, traps on illegal opcodes and counts retired instructions.
// Optional feature: define MC_ADDI_EN to decode addi (opcode 001000) through
// ADDI_EXEC/ADDI_WB; without it, addi traps like any illegal opcode.
module multicycle_main_control #(
   parameter int RETIRE_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [5:0]          opcode,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                pc_write_cond,
   output logic                iord,
   output logic                mem_read,
   output logic                mem_write,
   output logic                ir_write,
   output logic                mem_to_reg,
   output logic                reg_dst,
   output logic                reg_write,
   output logic                alu_src_a,
   output logic [1:0]          alu_src_b,
   output logic [1:0]          alu_op,
   output logic [1:0]          pc_source,
   output logic                instr_done,
   output logic                illegal_op,
   output logic [RETIRE_W-1:0] retired,
   output logic [3:0]          state
);
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_ALU_WB    = 4'd7,
      S_BRANCH    = 4'd8,
      S_JUMP      = 4'd9,
      S_ADDI_EXEC = 4'd10,
      S_ADDI_WB   = 4'd11,
      S_TRAP      = 4'd12
   } state_t;

   state_t              r_state;
   logic [5:0]          r_opcode;
   logic [RETIRE_W-1:0] r_retired;
   logic                w_instr_done;

   // State sequencing, opcode capture in DECODE and retired-instruction count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FETCH;
         r_opcode  <= '0;
         r_retired <= '0;
      end else begin
         if (w_instr_done)
            r_retired <= r_retired + RETIRE_W'(1);
         case (r_state)
            S_FETCH:     if (mem_ready) r_state <= S_DECODE;
            S_DECODE: begin
               r_opcode <= opcode;
               if (opcode == OP_LW || opcode == OP_SW) r_state <= S_MEM_ADDR;
               else if (opcode == OP_RTYPE)            r_state <= S_EXECUTE;
               else if (opcode == OP_BEQ)              r_state <= S_BRANCH;
               else if (opcode == OP_J)                r_state <= S_JUMP;
`ifdef MC_ADDI_EN
               else if (opcode == OP_ADDI)             r_state <= S_ADDI_EXEC;
`endif
               else                                    r_state <= S_TRAP;
            end
            S_MEM_ADDR:  r_state <= (r_opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ:  if (mem_ready) r_state <= S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) r_state <= S_FETCH;
            S_EXECUTE:   r_state <= S_ALU_WB;
`ifdef MC_ADDI_EN
            S_ADDI_EXEC: r_state <= S_ADDI_WB;
`endif
            S_TRAP:      r_state <= S_TRAP;
            default:     r_state <= S_FETCH;
         endcase
      end
   end

   // Moore decode of control strobes; only fetch strobes and the sw completion look at mem_ready
   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      pc_source     = 2'b00;
      w_instr_done  = 1'b0;
      illegal_op    = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE:    alu_src_b = 2'b11;
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            iord     = 1'b1;
         end
         S_MEM_WB: begin
            mem_to_reg   = 1'b1;
            reg_write    = 1'b1;
            w_instr_done = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write    = 1'b1;
            iord         = 1'b1;
            w_instr_done = mem_ready;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_ALU_WB: begin
            reg_dst      = 1'b1;
            reg_write    = 1'b1;
            w_instr_done = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
            w_instr_done  = 1'b1;
         end
         S_JUMP: begin
            pc_write     = 1'b1;
            pc_source    = 2'b10;
            w_instr_done = 1'b1;
         end
`ifdef MC_ADDI_EN
         S_ADDI_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_ADDI_WB: begin
            reg_write    = 1'b1;
            w_instr_done = 1'b1;
         end
`endif
         S_TRAP:      illegal_op = 1'b1;
         default:     illegal_op = 1'b0;
      endcase
   end

   assign instr_done = w_instr_done;
   assign retired    = r_retired;
   assign state      = r_state;

endmodule

// File: tb/tb_multicycle_main_control.sv
// tb_multicycle_main_control: randomized instruction streams checked against a
// per-instruction state-path model and a per-state control table.
module tb_multicycle_main_control;
   localparam int RW = 4;
   localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
   localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000;
`ifdef MC_ADDI_EN
   localparam bit ADDI_EN = 1'b1;
`else
   localparam bit ADDI_EN = 1'b0;
`endif

   typedef struct packed {
      logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rwr, asa;
      logic [1:0] asb, aop, psrc;
      logic done, ill;
   } sig_t;

   logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
   logic [5:0] opcode = '0;
   logic pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic mem_to_reg, reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [RW-1:0] retired;
   logic [3:0] state;

   int checks = 0, failures = 0;
   logic [RW-1:0] exp_ret = '0;

   multicycle_main_control #(.RETIRE_W(RW)) dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
      .retired(retired), .state(state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Control values each state must show, straight from the state table
   function automatic sig_t exp_sig(input int s, input logic rdy);
      sig_t e;
      e = '0;
      case (s)
         0:  begin e.mrd = 1; e.asb = 2'b01; e.irw = rdy; e.pcw = rdy; end
         1:  e.asb = 2'b11;
         2:  begin e.asa = 1; e.asb = 2'b10; end
         3:  begin e.mrd = 1; e.iord = 1; end
         4:  begin e.m2r = 1; e.rwr = 1; e.done = 1; end
         5:  begin e.mwr = 1; e.iord = 1; e.done = rdy; end
         6:  begin e.asa = 1; e.aop = 2'b10; end
         7:  begin e.rdst = 1; e.rwr = 1; e.done = 1; end
         8:  begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.psrc = 2'b01; e.done = 1; end
         9:  begin e.pcw = 1; e.psrc = 2'b10; e.done = 1; end
         10: begin e.asa = 1; e.asb = 2'b10; end
         11: begin e.rwr = 1; e.done = 1; end
         12: e.ill = 1;
         default: e = '0;
      endcase
      return e;
   endfunction

   task automatic cyc(input int s, input logic rdy, input logic [5:0] op);
      sig_t e, a;
      @(negedge clk);
      mem_ready = rdy;
      opcode = (s == 1) ? op : 6'($urandom);
      #1;
      e = exp_sig(s, rdy);
      a = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, mem_to_reg,
           reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};
      check($sformatf("state_in_%0d", s), 32'(state), 32'(s));
      check($sformatf("ctrl_in_%0d", s), 32'(a), 32'(e));
      @(posedge clk);
      #1;
      if (e.done) exp_ret++;
      check("retired", 32'(retired), 32'(exp_ret));
   endtask

   task automatic do_reset();
      @(negedge clk);
      mem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_state", 32'(state), 32'd0);
      check("rst_retired", 32'(retired), 32'd0);
      check("rst_strobes", 32'({mem_write, reg_write, pc_write, pc_write_cond, ir_write,
                                instr_done, illegal_op}), 32'd0);
      exp_ret = '0;
      @(posedge clk);
      #1 check("rst_hold", 32'(state), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Expected state path of one instruction, from its opcode and wait counts
   task automatic run_instr(input logic [5:0] op, input int wf, input int wm);
      repeat (wf) cyc(0, 1'b0, op);
      cyc(0, 1'b1, op);
      cyc(1, 1'($urandom), op);
      if (op == LW) begin
         cyc(2, 1'($urandom), op);
         repeat (wm) cyc(3, 1'b0, op);
         cyc(3, 1'b1, op);
         cyc(4, 1'($urandom), op);
      end else if (op == SW) begin
         cyc(2, 1'($urandom), op);
         repeat (wm) cyc(5, 1'b0, op);
         cyc(5, 1'b1, op);
      end else if (op == RT) begin
         cyc(6, 1'($urandom), op);
         cyc(7, 1'($urandom), op);
      end else if (op == BEQ) begin
         cyc(8, 1'($urandom), op);
      end else if (op == JMP) begin
         cyc(9, 1'($urandom), op);
      end else if (op == ADDI && ADDI_EN) begin
         cyc(10, 1'($urandom), op);
         cyc(11, 1'($urandom), op);
      end else begin
         repeat (20) cyc(12, 1'($urandom), op);
         do_reset();
      end
   endtask

   initial begin
      int k;
      logic [5:0] op;
      repeat (3) @(posedge clk);
      #1;
      check("init_state", 32'(state), 32'd0);
      check("init_retired", 32'(retired), 32'd0);
      check("init_illegal", 32'(illegal_op), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_instr(RT, 0, 0);
      run_instr(LW, 2, 3);
      run_instr(BEQ, 0, 0);
      run_instr(SW, 1, 2);
      run_instr(JMP, 0, 0);
      run_instr(ADDI, 0, 0);
      for (int n = 0; n < 150; n++) begin
         k = $urandom_range(0, 19);
         op = (k < 4) ? LW : (k < 7) ? SW : (k < 10) ? RT : (k < 13) ? BEQ :
              (k < 15) ? JMP : (k < 18) ? ADDI : 6'($urandom);
         run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3));
      end
      cyc(0, 1'b1, LW);
      cyc(1, 1'b1, LW);
      cyc(2, 1'b1, LW);
      cyc(3, 1'b0, LW);
      do_reset();
      run_instr(RT, 0, 0);
      run_instr(6'b111111, 1, 0);
      run_instr(BEQ, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
